hssl_link_ctrl: RTL and testbench
=================================

// Module: hssl_link_ctrl
// PURPOSE
//  Bring-up/recovery sequencer for the HSSL transceiver (GTP/GTH). Drives TX/RX datapath resets and TX elec-idle,
//  waits for reset-done and comma alignment, declares link up, monitors RX decode errors, and re-runs RX reset on
//  loss of sync. Sits beside hssl_transceiver in the free-running clock domain; all *_in status is pre-synchronised.
// PARAMETERS
//  RST_PULSE   16     cycles each datapath reset is held high
//  DONE_TMO    65536  cycles to wait for *_reset_done/usrclk_active before retry
//  ALIGN_TMO   4096   cycles to wait for comma detect before retry
//  ERR_WIN     1024   error-monitor window length (cycles)
//  ERR_THR     8      errored cycles in one window that force resync (1..ERR_WIN)
//  BACKOFF     256    idle cycles between a failure and the next attempt
// PORTS
//  freerun_clk_in          in   1   free-running clock, sole clock
//  reset_all_in            in   1   synchronous, active-high reset
//  tx_usrclk_active_in     in   1   TX user clock running
//  tx_reset_done_in        in   1   TX reset sequence complete
//  rx_reset_done_in        in   1   RX reset sequence complete
//  rx_commadet_in          in   1   comma seen (level, synchronised)
//  rx_error_in             in   1   OR of disperr/encerr/bufstatus, synchronised
//  tx_reset_datapath_out   out  1   TX datapath reset request
//  rx_reset_datapath_out   out  1   RX datapath reset request
//  tx_elecidle_out         out  1   hold TX in electrical idle
//  link_up_out             out  1   link usable
//  state_out               out  3   current FSM state encoding
//  retry_cnt_out           out  8   failed attempts since reset, saturating at 255
// BEHAVIOUR
//  Reset: state=IDLE, tx/rx_reset_datapath_out=0, tx_elecidle_out=1, link_up_out=0, retry_cnt_out=0, counters=0.
//  All outputs registered (1-cycle latency from state change). One shared down-counter timer, reloaded on every
//  state entry; timer width = clog2 of largest timer param.
//  States (state_out):
//   IDLE(0): wait tx_usrclk_active_in=1 -> TX_RST. No timeout.
//   TX_RST(1): tx_reset_datapath_out=1 for exactly RST_PULSE cycles -> TX_WAIT.
//   TX_WAIT(2): tx_reset_done_in=1 -> RX_RST; DONE_TMO expiry -> FAIL.
//   RX_RST(3): rx_reset_datapath_out=1 for exactly RST_PULSE cycles -> RX_WAIT. tx_elecidle_out drops to 0 here.
//   RX_WAIT(4): rx_reset_done_in=1 -> ALIGN; DONE_TMO expiry -> FAIL.
//   ALIGN(5): rx_commadet_in=1 -> UP; ALIGN_TMO expiry -> FAIL.
//   UP(6): link_up_out=1. Window counter counts 0..ERR_WIN-1 and wraps; errored-cycle counter clears at wrap.
//     Errored count reaching ERR_THR -> FAIL (same cycle threshold met; wrap and hit simultaneous => FAIL wins).
//     rx_reset_done_in=0 or tx_reset_done_in=0 -> FAIL.
//   FAIL(7): link_up_out=0, retry_cnt_out+=1 (saturating), BACKOFF cycles; then -> RX_RST if tx_reset_done_in=1
//     and tx_usrclk_active_in=1, else -> IDLE (full TX+RX restart, tx_elecidle_out=1).
//  tx_usrclk_active_in=0 in any state except IDLE -> IDLE immediately (no retry increment).
//  reset_all_in mid-operation: return to reset values next cycle regardless of state; retry count cleared.
//  link_up_out falls in the same cycle state leaves UP (registered: visible 1 cycle after cause).
// STRUCTURE
//  Package hssl_pkg: state enum/localparams (IDLE..FAIL, 3 bits), state_out width, retry counter width.
//  One sub-module natural: hssl_err_monitor (window + errored-cycle counter, enable=state UP, out: thr_hit).
//  Timer and FSM inline in hssl_link_ctrl.
// TESTING (bench params RST_PULSE=4, DONE_TMO=64, ALIGN_TMO=32, ERR_WIN=16, ERR_THR=3, BACKOFF=8)
//  Clean bring-up: active=1, tx_done 10 cyc after TX_RST, rx_done 10 cyc after RX_RST, commadet -> UP; each reset
//   pulse exactly 4 cycles, link_up_out=1, retry_cnt_out=0.
//  TX timeout: tx_reset_done_in stuck 0 -> FAIL after 64 cyc in TX_WAIT, retry=1, 8 cyc backoff, back to IDLE/TX_RST.
//  Error burst: in UP, 3 errored cycles within 16 -> FAIL, link_up_out=0, then RX_RST only (tx_reset_datapath_out
//   stays 0); 2 errors per window for 10 windows -> stays UP.
//  Align timeout: commadet never asserted -> FAIL after 32 cyc in ALIGN; repeat 300 times -> retry_cnt_out=255.
//  Clock loss: tx_usrclk_active_in=0 while UP -> IDLE, tx_elecidle_out=1, retry unchanged.
//  Reset mid-RX_RST: reset_all_in for 1 cycle -> all outputs at reset values next cycle, state_out=0.

Source files
------------

// File: rtl/hssl_pkg.sv
// Shared types and widths for the HSSL link bring-up/recovery sequencer.
package hssl_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 8;

  // FSM state encoding; values are exported unchanged on state_out.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_TX_RST  = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_RX_RST  = 3'd3,
    ST_RX_WAIT = 3'd4,
    ST_ALIGN   = 3'd5,
    ST_UP      = 3'd6,
    ST_FAIL    = 3'd7
  } state_t;

  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  // Used to size the shared timer from the largest timeout parameter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hssl_err_monitor.sv
// RX error monitor: counts errored cycles inside a fixed-length window while the
// link is up and flags the cycle on which the count reaches the threshold.
module hssl_err_monitor #(
  parameter int ERR_WIN = 1024,
  parameter int ERR_THR = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic err,
  output logic thr_hit
);

  localparam int WIN_W = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int CNT_W = $clog2(ERR_THR + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             win_last;

  assign win_last = (win_cnt == WIN_W'(ERR_WIN - 1));

  // Combinational so the FSM can leave UP on the very edge that samples the
  // threshold-reaching error; this also makes a hit in the last window cycle
  // win over the window wrap that would otherwise clear the count.
  assign thr_hit = enable && err && (err_cnt == CNT_W'(ERR_THR - 1));

  // Window position and errored-cycle count; both restart whenever UP is left.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else begin
      win_cnt <= win_last ? '0 : win_cnt + 1'b1;
      if (win_last) begin
        err_cnt <= '0;
      end else if (err && !thr_hit) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hssl_link_ctrl.sv
// HSSL transceiver bring-up/recovery sequencer. Pulses the TX and RX datapath
// resets, waits for reset-done and comma alignment, declares link up, watches
// RX decode errors and re-runs the RX side (or a full restart) on loss of sync.
//
// Handshakes: there are no valid/ready pairs here; every *_in status is a
// pre-synchronised level sampled on each free-running clock edge, and every
// output is a registered level that changes on the same edge as state_out.
module hssl_link_ctrl
  import hssl_pkg::*;
#(
  parameter int RST_PULSE = 16,
  parameter int DONE_TMO  = 65536,
  parameter int ALIGN_TMO = 4096,
  parameter int ERR_WIN   = 1024,
  parameter int ERR_THR   = 8,
  parameter int BACKOFF   = 256
) (
  input  logic               freerun_clk_in,
  input  logic               reset_all_in,
  input  logic               tx_usrclk_active_in,
  input  logic               tx_reset_done_in,
  input  logic               rx_reset_done_in,
  input  logic               rx_commadet_in,
  input  logic               rx_error_in,
  output logic               tx_reset_datapath_out,
  output logic               rx_reset_datapath_out,
  output logic               tx_elecidle_out,
  output logic               link_up_out,
  output logic [STATE_W-1:0] state_out,
  output logic [RETRY_W-1:0] retry_cnt_out
);

  localparam int TMR_MAX = max_int(max_int(RST_PULSE, DONE_TMO), max_int(ALIGN_TMO, BACKOFF));
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] timer;
  logic             tmr_zero;
  logic             thr_hit;

  // Value loaded into the shared down-counter on entry to a state; the state
  // is left on the cycle the counter reads zero, giving exactly N cycles.
  function automatic logic [TMR_W-1:0] reload(input state_t s);
    case (s)
      ST_TX_RST, ST_RX_RST:   return TMR_W'(RST_PULSE - 1);
      ST_TX_WAIT, ST_RX_WAIT: return TMR_W'(DONE_TMO - 1);
      ST_ALIGN:               return TMR_W'(ALIGN_TMO - 1);
      ST_FAIL:                return TMR_W'(BACKOFF - 1);
      default:                return '0;
    endcase
  endfunction

  assign tmr_zero  = (timer == '0);
  assign state_out = state;

  hssl_err_monitor #(
    .ERR_WIN (ERR_WIN),
    .ERR_THR (ERR_THR)
  ) u_err_monitor (
    .clk     (freerun_clk_in),
    .rst     (reset_all_in),
    .enable  (state == ST_UP),
    .err     (rx_error_in),
    .thr_hit (thr_hit)
  );

  // Next-state decode; losing the TX user clock overrides every other exit.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (tx_usrclk_active_in) next_state = ST_TX_RST;
      ST_TX_RST:  if (tmr_zero) next_state = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (tx_reset_done_in)  next_state = ST_RX_RST;
        else if (tmr_zero)     next_state = ST_FAIL;
      end
      ST_RX_RST:  if (tmr_zero) next_state = ST_RX_WAIT;
      ST_RX_WAIT: begin
        if (rx_reset_done_in)  next_state = ST_ALIGN;
        else if (tmr_zero)     next_state = ST_FAIL;
      end
      ST_ALIGN: begin
        if (rx_commadet_in)    next_state = ST_UP;
        else if (tmr_zero)     next_state = ST_FAIL;
      end
      ST_UP: begin
        if (thr_hit || !rx_reset_done_in || !tx_reset_done_in) next_state = ST_FAIL;
      end
      ST_FAIL: begin
        if (tmr_zero) begin
          next_state = (tx_reset_done_in && tx_usrclk_active_in) ? ST_RX_RST : ST_IDLE;
        end
      end
      default:    next_state = ST_IDLE;
    endcase
    if (state != ST_IDLE && !tx_usrclk_active_in) next_state = ST_IDLE;
  end

  // State, shared timer and outputs; outputs decode next_state so they line up with state_out.
  always_ff @(posedge freerun_clk_in) begin
    if (reset_all_in) begin
      state                 <= ST_IDLE;
      timer                 <= '0;
      tx_reset_datapath_out <= 1'b0;
      rx_reset_datapath_out <= 1'b0;
      tx_elecidle_out       <= 1'b1;
      link_up_out           <= 1'b0;
      retry_cnt_out         <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        timer <= reload(next_state);
      end else if (!tmr_zero) begin
        timer <= timer - 1'b1;
      end
      tx_reset_datapath_out <= (next_state == ST_TX_RST);
      rx_reset_datapath_out <= (next_state == ST_RX_RST);
      link_up_out           <= (next_state == ST_UP);
      // Electrical idle is released when the RX side is first reset and only
      // re-asserted by a full restart from IDLE.
      if (next_state == ST_IDLE) begin
        tx_elecidle_out <= 1'b1;
      end else if (next_state == ST_RX_RST) begin
        tx_elecidle_out <= 1'b0;
      end
      if (next_state == ST_FAIL && state != ST_FAIL && retry_cnt_out != RETRY_MAX) begin
        retry_cnt_out <= retry_cnt_out + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hssl_link_ctrl.sv
// Directed bench for hssl_link_ctrl with shortened timing parameters.
module tb_hssl_link_ctrl;
  import hssl_pkg::*;

  localparam int RST_PULSE = 4;
  localparam int DONE_TMO  = 64;
  localparam int ALIGN_TMO = 32;
  localparam int ERR_WIN   = 16;
  localparam int ERR_THR   = 3;
  localparam int BACKOFF   = 8;

  logic       clk       = 1'b0;
  logic       reset_all = 1'b1;
  logic       active    = 1'b0;
  logic       tx_done   = 1'b0;
  logic       rx_done   = 1'b0;
  logic       commadet  = 1'b0;
  logic       rx_error  = 1'b0;
  logic       tx_rst;
  logic       rx_rst;
  logic       elecidle;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retry;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  hssl_link_ctrl #(
    .RST_PULSE (RST_PULSE),
    .DONE_TMO  (DONE_TMO),
    .ALIGN_TMO (ALIGN_TMO),
    .ERR_WIN   (ERR_WIN),
    .ERR_THR   (ERR_THR),
    .BACKOFF   (BACKOFF)
  ) dut (
    .freerun_clk_in        (clk),
    .reset_all_in          (reset_all),
    .tx_usrclk_active_in   (active),
    .tx_reset_done_in      (tx_done),
    .rx_reset_done_in      (rx_done),
    .rx_commadet_in        (commadet),
    .rx_error_in           (rx_error),
    .tx_reset_datapath_out (tx_rst),
    .rx_reset_datapath_out (rx_rst),
    .tx_elecidle_out       (elecidle),
    .link_up_out           (link_up),
    .state_out             (state),
    .retry_cnt_out         (retry)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    for (int i = 0; i < budget && state != target; i++) tick();
    check(tag, int'(state), int'(target));
  endtask

  // One error-monitor window (or part of one): rx_error follows mask bit j on cycle j.
  task automatic win_errors(input logic [15:0] mask, input int n, inout int down_cnt);
    for (int j = 0; j < n; j++) begin
      rx_error = mask[j];
      tick();
      if (!link_up) down_cnt++;
    end
    rx_error = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    int'(state),    0);
    check({tag, "_tx_rst"},   int'(tx_rst),   0);
    check({tag, "_rx_rst"},   int'(rx_rst),   0);
    check({tag, "_elecidle"}, int'(elecidle), 1);
    check({tag, "_link_up"},  int'(link_up),  0);
    check({tag, "_retry"},    int'(retry),    0);
  endtask

  initial begin
    int tx_cnt;
    int rx_cnt;
    int down_cnt;

    // Reset
    reset_all = 1'b1;
    ticks(2);
    check_reset_values("reset");
    reset_all = 1'b0;
    tick();
    check("idle_no_clk", int'(state), 0);

    // Clean bring-up
    active = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back((i < RST_PULSE) ? 3'd1 : 3'd2);
    tx_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] e;
      tick();
      e = exp_q.pop_front();
      check("bringup_seq", int'(state), int'(e));
      tx_cnt += int'(tx_rst);
    end
    check("tx_pulse_len", tx_cnt, 4);
    check("elecidle_tx_wait", int'(elecidle), 1);
    tx_done = 1'b1;
    tick();
    check("rx_rst_entry", int'(state), 3);
    check("elecidle_rx_rst", int'(elecidle), 0);
    rx_cnt = int'(rx_rst);
    for (int i = 0; i < 9; i++) begin
      tick();
      rx_cnt += int'(rx_rst);
    end
    check("rx_pulse_len", rx_cnt, 4);
    check("rx_wait_state", int'(state), 4);
    rx_done = 1'b1;
    tick();
    check("align_state", int'(state), 5);
    commadet = 1'b1;
    tick();
    check("up_state", int'(state), 6);
    check("up_link", int'(link_up), 1);
    check("up_retry", int'(retry), 0);

    // Error burst: three errored cycles in one window
    rx_error = 1'b1;
    ticks(2);
    check("burst_2err_up", int'(state), 6);
    tick();
    rx_error = 1'b0;
    check("burst_fail", int'(state), 7);
    check("burst_link_down", int'(link_up), 0);
    check("burst_retry", int'(retry), 1);
    tx_cnt = 0;
    for (int i = 0; i < BACKOFF - 1; i++) begin
      tick();
      tx_cnt += int'(tx_rst);
    end
    check("burst_backoff", int'(state), 7);
    tick();
    tx_cnt += int'(tx_rst);
    check("burst_rx_only", int'(state), 3);
    wait_state(3'd6, 20, "burst_reup");
    check("burst_no_tx_rst", tx_cnt + int'(tx_rst), 0);

    // Two errors per window for ten windows stays up
    down_cnt = 0;
    for (int w = 0; w < 10; w++) win_errors(16'h0208, 16, down_cnt);
    check("two_err_down_cycles", down_cnt, 0);
    check("two_err_state", int'(state), 6);
    // Errors straddling the wrap count in different windows
    win_errors(16'hC000, 16, down_cnt);
    win_errors(16'h0001, 16, down_cnt);
    check("wrap_split_state", int'(state), 6);
    check("wrap_split_down", down_cnt, 0);
    // Third error in the last cycle of a window: threshold wins over wrap
    win_errors(16'h0006, 15, down_cnt);
    check("wrap_hit_pre", int'(state), 6);
    win_errors(16'h0001, 1, down_cnt);
    check("wrap_hit_fail", int'(state), 7);
    check("wrap_hit_retry", int'(retry), 2);
    wait_state(3'd6, 40, "wrap_reup");

    // Loss of rx_reset_done while up
    rx_done = 1'b0;
    tick();
    check("rxdone_drop_fail", int'(state), 7);
    check("rxdone_drop_retry", int'(retry), 3);
    rx_done = 1'b1;
    wait_state(3'd6, 40, "rxdone_reup");

    // Clock loss while up
    active = 1'b0;
    tick();
    check("clkloss_state", int'(state), 0);
    check("clkloss_elecidle", int'(elecidle), 1);
    check("clkloss_link", int'(link_up), 0);
    check("clkloss_retry", int'(retry), 3);

    // TX timeout
    reset_all = 1'b1;
    tick();
    reset_all = 1'b0;
    tx_done   = 1'b0;
    rx_done   = 1'b0;
    commadet  = 1'b0;
    active    = 1'b1;
    tick();
    check("txtmo_tx_rst", int'(state), 1);
    ticks(RST_PULSE + DONE_TMO - 1);
    check("txtmo_last_wait", int'(state), 2);
    tick();
    check("txtmo_fail", int'(state), 7);
    check("txtmo_retry", int'(retry), 1);
    ticks(BACKOFF - 1);
    check("txtmo_backoff", int'(state), 7);
    tick();
    check("txtmo_idle", int'(state), 0);
    check("txtmo_elecidle", int'(elecidle), 1);
    tick();
    check("txtmo_restart", int'(state), 1);
    check("txtmo_restart_txrst", int'(tx_rst), 1);

    // Align timeout and retry saturation
    reset_all = 1'b1;
    tick();
    reset_all = 1'b0;
    tx_done   = 1'b1;
    rx_done   = 1'b1;
    wait_state(3'd5, 40, "aligntmo_enter");
    ticks(ALIGN_TMO - 1);
    check("aligntmo_last", int'(state), 5);
    tick();
    check("aligntmo_fail", int'(state), 7);
    check("aligntmo_retry", int'(retry), 1);
    for (int k = 2; k <= 300; k++) begin
      wait_state(3'd5, 30, "aligntmo_loop_align");
      wait_state(3'd7, 40, "aligntmo_loop_fail");
      if (k == 254) check("retry_254", int'(retry), 254);
      if (k == 255) check("retry_255", int'(retry), 255);
    end
    check("retry_saturated", int'(retry), 255);

    // Reset in the middle of RX_RST
    wait_state(3'd3, 20, "midrst_enter");
    check("midrst_rx_rst", int'(rx_rst), 1);
    reset_all = 1'b1;
    tick();
    check_reset_values("midrst");
    reset_all = 1'b0;
    tick();
    check("midrst_restart", int'(state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
